// File: rtl/alu_exec_stage_if.sv
// Handshake and operand/result bundle between issue, the execute stage and writeback.
// master = upstream/downstream side (bench), slave = the execute stage.
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_x, in_y, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_x, in_y, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered MIPS32 execute stage: single-cycle ALU ops plus a sliced multi-cycle
// Hamming-distance op, with valid/ready on both sides.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_exec_stage_if.slave   bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpNor  = 4'd3;
  localparam logic [3:0] OpAdd  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpSltu = 4'd7;
  localparam logic [3:0] OpSll  = 4'd8;
  localparam logic [3:0] OpSrl  = 4'd9;
  localparam logic [3:0] OpSra  = 4'd10;
  localparam logic [3:0] OpHam  = 4'd11;

  typedef enum logic [1:0] {StIdle, StHamRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, err_q;

  logic             accept;
  logic             is_ham;
  logic             last_slice;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] diff_sh;
  logic [SLICE-1:0] slice;
  logic [WIDTH-1:0] pop;
  logic [WIDTH-1:0] ham_sum;
  logic [4:0]       shamt;

  assign accept     = bus.in_valid && bus.in_ready;
  assign is_ham     = (bus.in_op == OpHam);
  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));
  assign shamt      = bus.in_y[4:0];

  // Single-cycle ops read the live inputs; their result is captured at the accept edge.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.in_op)
      OpAnd:   alu_res = bus.in_x & bus.in_y;
      OpOr:    alu_res = bus.in_x | bus.in_y;
      OpXor:   alu_res = bus.in_x ^ bus.in_y;
      OpNor:   alu_res = ~(bus.in_x | bus.in_y);
      OpAdd:   alu_res = bus.in_x + bus.in_y;
      OpSub:   alu_res = bus.in_x - bus.in_y;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_x) < $signed(bus.in_y))};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (bus.in_x < bus.in_y)};
      OpSll:   alu_res = bus.in_x << shamt;
      OpSrl:   alu_res = bus.in_x >> shamt;
      OpSra:   alu_res = $signed(bus.in_x) >>> shamt;
      OpHam:   alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    diff_sh = (x_q ^ y_q) >> (32'(cnt_q) * SLICE);
    slice   = diff_sh[SLICE-1:0];
    pop     = '0;
    for (int i = 0; i < int'(SLICE); i++) begin
      pop = pop + {{(WIDTH-1){1'b0}}, slice[i]};
    end
    ham_sum = acc_q + pop;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = is_ham ? StHamRun : StHold;
      StHamRun: if (last_slice) state_d = StHold;
      StHold: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = is_ham ? StHamRun : StHold;
          else              state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == StIdle) || ((state_q == StHold) && bus.out_ready);
    bus.out_valid = (state_q == StHold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      x_q   <= bus.in_x;
      y_q   <= bus.in_y;
      cnt_q <= '0;
      acc_q <= '0;
      if (!is_ham) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        err_q    <= alu_err;
      end
    end else if (state_q == StHamRun) begin
      acc_q <= ham_sum;
      cnt_q <= cnt_q + 1'b1;
      if (last_slice) begin
        result_q <= ham_sum;
        zero_q   <= (ham_sum == '0);
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_exec_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(
    .WIDTH(32),
    .SLICE(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_x     = x;
    bus.in_y     = y;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    #3;
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.out_result, 32'h0);
    chk("rst_zero", {31'b0, bus.out_zero}, 32'd0);
    chk("rst_err", {31'b0, bus.out_err}, 32'd0);
    chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
    #4 rst_n = 1'b1;
    cyc();

    // AND, latency 1
    drive(1'b1, 4'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("and_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("and_result", bus.out_result, 32'h00F000F0);
    chk("and_zero", {31'b0, bus.out_zero}, 32'd0);
    chk("and_err", {31'b0, bus.out_err}, 32'd0);
    cyc();
    chk("and_retired", {31'b0, bus.out_valid}, 32'd0);

    // SUB back-to-back
    drive(1'b1, 4'd5, 32'd5, 32'd5);
    #1 chk("sub_ready0", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    drive(1'b1, 4'd5, 32'd0, 32'd1);
    #1;
    chk("sub0_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("sub0_result", bus.out_result, 32'h0);
    chk("sub0_zero", {31'b0, bus.out_zero}, 32'd1);
    chk("sub_ready1", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("sub1_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("sub1_result", bus.out_result, 32'hFFFFFFFF);
    chk("sub1_zero", {31'b0, bus.out_zero}, 32'd0);
    cyc();

    // SLT, SLTU, SRA back-to-back
    drive(1'b1, 4'd6, 32'hFFFFFFFF, 32'h00000001);
    cyc();
    drive(1'b1, 4'd7, 32'hFFFFFFFF, 32'h00000001);
    chk("slt_result", bus.out_result, 32'd1);
    cyc();
    drive(1'b1, 4'd10, 32'h80000000, 32'd4);
    chk("sltu_result", bus.out_result, 32'd0);
    chk("sltu_zero", {31'b0, bus.out_zero}, 32'd1);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("sra_result", bus.out_result, 32'hF8000000);
    cyc();

    // HAM: 4 busy cycles, result on the 4th edge after accept
    drive(1'b1, 4'd11, 32'hFFFF0000, 32'h0000FFFF);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("ham_busy_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("ham_busy_valid", {31'b0, bus.out_valid}, 32'd0);
      cyc();
    end
    chk("ham_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ham_result", bus.out_result, 32'h00000020);
    chk("ham_zero", {31'b0, bus.out_zero}, 32'd0);
    cyc();

    // Backpressure: result held while out_ready=0, new op not taken
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd4, 32'd1, 32'd2);
    cyc();
    drive(1'b1, 4'd4, 32'd10, 32'd20);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_result", bus.out_result, 32'd3);
      chk("bp_ready", {31'b0, bus.in_ready}, 32'd0);
      cyc();
    end
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    #1 chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    cyc();
    chk("bp_retired", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_idle_hold", bus.out_result, 32'd3);

    // Reset during HAM cycle 2 discards the partial op
    drive(1'b1, 4'd11, 32'h0, 32'hFFFFFFFF);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_result", bus.out_result, 32'h0);
    chk("mid_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_novalid", {31'b0, bus.out_valid}, 32'd0);
    end

    // Illegal opcode, then a legal op clears out_err
    drive(1'b1, 4'd13, 32'h12345678, 32'h9ABCDEF0);
    cyc();
    drive(1'b1, 4'd1, 32'h00000001, 32'h00000000);
    chk("ill_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ill_err", {31'b0, bus.out_err}, 32'd1);
    chk("ill_result", bus.out_result, 32'h0);
    chk("ill_zero", {31'b0, bus.out_zero}, 32'd1);
    cyc();
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    chk("or_err_clear", {31'b0, bus.out_err}, 32'd0);
    chk("or_result", bus.out_result, 32'd1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage of the MIPS32 datapath; sits between decode/issue and writeback.
- Latches the operand pair and ALU opcode, drives the 32-bit bitwise, arithmetic and shift logic, and registers the result with a zero flag.
- Adds a multi-cycle Hamming-distance op processed one slice per cycle.
- valid/ready handshake on both sides so writeback can stall it.

Parameters:
WIDTH  32  datapath width; must be a multiple of SLICE
SLICE  8   bits per Hamming iteration; HAM latency = WIDTH/SLICE cycles

Ports:
clk         input   1      rising-edge clock
rst_n       input   1      asynchronous active-low reset
in_valid    input   1      upstream offers an op
in_ready    output  1      stage can accept this cycle
in_x        input   WIDTH  operand A (value to shift for shifts)
in_y        input   WIDTH  operand B (shift amount in in_y[4:0])
in_op       input   4      opcode (see Behaviour)
out_valid   output  1      result valid
out_ready   input   1      downstream accepts result
out_result  output  WIDTH  registered result
out_zero    output  1      out_result == 0
out_err     output  1      opcode was illegal

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; out_result=0; out_zero=0; out_err=0; slice counter=0; accumulator=0; latched operands=0. Applies immediately, mid-HAM included; the partial op is discarded and never emitted.
- Opcodes:
  - 0 AND; 1 OR; 2 XOR; 3 NOR.
  - 4 ADD; 5 SUB: both modulo 2^WIDTH, no overflow trap.
  - 6 SLT: signed, result 1/0; 7 SLTU: unsigned, result 1/0.
  - 8 SLL; 9 SRL; 10 SRA: shift amount in_y[4:0].
  - 11 HAM: popcount(in_x ^ in_y), zero-extended.
  - 12-15 illegal.
- Accept: in_valid && in_ready at a clock edge. in_x, in_y and in_op are latched; later input changes have no effect.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational from out_ready.
- States:
  - IDLE:
    - Single-cycle op accepted -> HOLD. Result, out_zero and out_err are registered at the accept edge, so out_valid=1 the next cycle (latency 1).
    - HAM accepted -> HAM_RUN with counter=0 and accumulator=0.
    - No accept -> stay IDLE.
  - HAM_RUN:
    - Each cycle, accumulator += popcount of slice[counter] of (x^y); counter increments.
    - On the edge processing the last slice (counter == WIDTH/SLICE-1), the final sum is written to out_result -> HOLD.
    - out_valid rises WIDTH/SLICE cycles after accept (4 at defaults).
    - in_ready=0 throughout.
  - HOLD:
    - out_valid=1; out_result, out_zero and out_err are held stable until out_ready=1.
    - out_ready && in_valid: the result retires and the new op is accepted on the same edge (back-to-back, no bubble for single-cycle ops).
    - out_ready && !in_valid -> IDLE, out_valid=0.
    - !out_ready -> stay in HOLD.
- Illegal op: out_result=0, out_zero=1, out_err=1, latency 1. out_err clears when a legal op's result is registered.
- out_zero is computed from the registered result value, not re-derived from later inputs.
- Outputs hold their last values in IDLE; only out_valid is meaningful there.

Test Plan:
- AND x=0xF0F0F0F0, y=0x0FF00FF0, out_ready=1 -> one cycle later out_valid=1, out_result=0x00F000F0, out_zero=0, out_err=0.
- SUB 5-5 then SUB 0-1 back-to-back, in_valid held, out_ready=1 -> consecutive cycles give 0x00000000/zero=1, then 0xFFFFFFFF/zero=0; in_ready stays 1.
- SLT and SLTU with x=0xFFFFFFFF, y=0x00000001 -> 1 and 0 respectively. SRA x=0x80000000, y=4 -> 0xF8000000.
- HAM x=0xFFFF0000, y=0x0000FFFF -> in_ready=0 for 4 cycles; out_valid asserts 4 cycles after accept with out_result=0x00000020.
- Backpressure: after ADD 1+2, hold out_ready=0 for 5 cycles -> out_valid=1 and out_result=3 stable, in_ready=0; releasing out_ready retires it in that cycle.
- rst_n pulsed low during HAM cycle 2 -> out_valid=0 immediately and no result emitted. After release, opcode 13 -> out_err=1, out_result=0, out_zero=1.
